emac_rx_client_fifo: RTL and testbench



---
 rtl/emac_pkg.sv | 17 +
 rtl/emac_fifo_ram.sv | 23 ++
 rtl/emac_rx_client_fifo.sv | 150 +++++++++++++++
 tb/tb_emac_rx_client_fifo.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/emac_pkg.sv
// Shared types for the EMAC RX client FIFO: write FSM states and the stored entry format.
package emac_pkg;

  localparam int unsigned DataWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StDrop
  } wr_state_e;

  typedef struct packed {
    logic                 last;
    logic [DataWidth-1:0] data;
  } entry_t;

endpackage

// File: rtl/emac_fifo_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port, single clock.
module emac_fifo_ram
  import emac_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  entry_t                wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output entry_t                rdata
);

  entry_t mem [0:(1 << ADDR_WIDTH) - 1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/emac_rx_client_fifo.sv
// EMAC RX client adapter: buffers whole frames, releases only frames flagged good,
// and rolls back bad, filtered or overflowed frames before they reach the output.
module emac_rx_client_fifo
  import emac_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [DataWidth-1:0]  EMACCLIENTRXD,
  input  logic                  EMACCLIENTRXDVLD,
  input  logic                  EMACCLIENTRXGOODFRAME,
  input  logic                  EMACCLIENTRXBADFRAME,
  input  logic                  EMACCLIENTRXFRAMEDROP,
  output logic [DataWidth-1:0]  RX_DATA,
  output logic                  RX_VALID,
  output logic                  RX_LAST,
  input  logic                  RX_READY,
  output logic [ADDR_WIDTH:0]   FIFO_LEVEL,
  output logic [CNT_WIDTH-1:0]  FRAMES_OK,
  output logic [CNT_WIDTH-1:0]  FRAMES_BAD,
  output logic [CNT_WIDTH-1:0]  FRAMES_OVF
);

  localparam int unsigned PtrWidth = ADDR_WIDTH + 1;
  localparam logic [PtrWidth-1:0] Depth  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PtrWidth-1:0] PtrOne = PtrWidth'(1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  wr_state_e             state;
  logic [DataWidth-1:0]  hold;
  logic [PtrWidth-1:0]   wr_ptr, commit_ptr, rd_ptr, fetch_ptr;
  logic                  status, commit_ok, byte_wr, full, ram_we;
  logic                  ram_vld, ren, xfer, consume;
  entry_t                ram_wdata, ram_rdata;

  always_comb begin
    status    = EMACCLIENTRXGOODFRAME | EMACCLIENTRXBADFRAME;
    commit_ok = (state == StRecv) && EMACCLIENTRXGOODFRAME && !EMACCLIENTRXBADFRAME &&
                !EMACCLIENTRXFRAMEDROP;
    // Status beats a coincident byte, so only a status-free byte causes a data write.
    byte_wr   = (state == StRecv) && !status && EMACCLIENTRXDVLD;
    full      = (wr_ptr - rd_ptr) == Depth;
    ram_we    = (commit_ok || byte_wr) && !full;
    ram_wdata.last = commit_ok;
    ram_wdata.data = hold;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= StIdle;
      hold       <= '0;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      FRAMES_OK  <= '0;
      FRAMES_BAD <= '0;
      FRAMES_OVF <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (status) begin
            FRAMES_BAD <= sat_inc(FRAMES_BAD);
          end else if (EMACCLIENTRXDVLD) begin
            hold  <= EMACCLIENTRXD;
            state <= StRecv;
          end
        end
        StRecv: begin
          if (status) begin
            state <= StIdle;
            if (commit_ok && !full) begin
              wr_ptr     <= wr_ptr + PtrOne;
              commit_ptr <= wr_ptr + PtrOne;
              FRAMES_OK  <= sat_inc(FRAMES_OK);
            end else if (commit_ok) begin
              // No room for the final byte: the frame ended, so no need to drop.
              wr_ptr     <= commit_ptr;
              FRAMES_OVF <= sat_inc(FRAMES_OVF);
            end else begin
              wr_ptr     <= commit_ptr;
              FRAMES_BAD <= sat_inc(FRAMES_BAD);
            end
          end else if (EMACCLIENTRXDVLD) begin
            if (full) begin
              wr_ptr     <= commit_ptr;
              FRAMES_OVF <= sat_inc(FRAMES_OVF);
              state      <= StDrop;
            end else begin
              wr_ptr <= wr_ptr + PtrOne;
              hold   <= EMACCLIENTRXD;
            end
          end
        end
        StDrop: begin
          if (status) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Two-stage read pipeline: RAM output register feeds the output register.
  always_comb begin
    consume = RX_VALID && RX_READY;
    xfer    = ram_vld && (!RX_VALID || consume);
    ren     = (fetch_ptr != commit_ptr) && (!ram_vld || xfer);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fetch_ptr <= '0;
      rd_ptr    <= '0;
      ram_vld   <= 1'b0;
      RX_VALID  <= 1'b0;
      RX_DATA   <= '0;
      RX_LAST   <= 1'b0;
    end else begin
      if (ren) fetch_ptr <= fetch_ptr + PtrOne;
      if (ren) ram_vld <= 1'b1;
      else if (xfer) ram_vld <= 1'b0;
      if (consume) rd_ptr <= rd_ptr + PtrOne;
      if (xfer) begin
        RX_VALID <= 1'b1;
        RX_DATA  <= ram_rdata.data;
        RX_LAST  <= ram_rdata.last;
      end else if (consume) begin
        RX_VALID <= 1'b0;
      end
    end
  end

  assign FIFO_LEVEL = commit_ptr - rd_ptr;

  emac_fifo_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (CLK),
    .we   (ram_we),
    .waddr(wr_ptr[ADDR_WIDTH-1:0]),
    .wdata(ram_wdata),
    .re   (ren),
    .raddr(fetch_ptr[ADDR_WIDTH-1:0]),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_emac_rx_client_fifo.sv
// Scoreboard bench: a full-size instance for frame handling and a 16-entry instance for overflow.
module tb_emac_rx_client_fifo;

  logic       clk = 1'b0;
  logic       rst_m, rst_s;
  logic [7:0] rxd;
  logic       dvld, e_good, e_bad, e_drop;
  logic       ready_m, ready_s;

  logic [7:0]  data_m, data_s;
  logic        valid_m, valid_s, last_m, last_s;
  logic [11:0] level_m;
  logic [4:0]  level_s;
  logic [15:0] ok_m, bad_m, ovf_m, ok_s, bad_s, ovf_s;

  int total = 0;
  int nbad  = 0;
  int ready_mode = 0;
  logic [8:0] q_m[$];
  logic [8:0] q_s[$];

  always #5 clk = ~clk;

  emac_rx_client_fifo dut (
    .CLK(clk), .RESET_N(rst_m), .EMACCLIENTRXD(rxd), .EMACCLIENTRXDVLD(dvld),
    .EMACCLIENTRXGOODFRAME(e_good), .EMACCLIENTRXBADFRAME(e_bad),
    .EMACCLIENTRXFRAMEDROP(e_drop), .RX_DATA(data_m), .RX_VALID(valid_m), .RX_LAST(last_m),
    .RX_READY(ready_m), .FIFO_LEVEL(level_m), .FRAMES_OK(ok_m), .FRAMES_BAD(bad_m),
    .FRAMES_OVF(ovf_m)
  );

  emac_rx_client_fifo #(.ADDR_WIDTH(4), .CNT_WIDTH(16)) dut_s (
    .CLK(clk), .RESET_N(rst_s), .EMACCLIENTRXD(rxd), .EMACCLIENTRXDVLD(dvld),
    .EMACCLIENTRXGOODFRAME(e_good), .EMACCLIENTRXBADFRAME(e_bad),
    .EMACCLIENTRXFRAMEDROP(e_drop), .RX_DATA(data_s), .RX_VALID(valid_s), .RX_LAST(last_s),
    .RX_READY(ready_s), .FIFO_LEVEL(level_s), .FRAMES_OK(ok_s), .FRAMES_BAD(bad_s),
    .FRAMES_OVF(ovf_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // kind: 0 good, 1 bad, 2 good with address-filter drop. push_to: 0 none, 1 main, 2 small.
  task automatic send_frame(input int n, input int base, input int kind, input int push_to);
    for (int i = 0; i < n; i++) begin
      rxd  = 8'(base + i);
      dvld = 1'b1;
      if (push_to == 1) q_m.push_back({(i == n - 1), rxd});
      if (push_to == 2) q_s.push_back({(i == n - 1), rxd});
      @(posedge clk); #1;
    end
    dvld   = 1'b0;
    e_good = (kind != 1);
    e_bad  = (kind == 1);
    e_drop = (kind == 2);
    @(posedge clk); #1;
    e_good = 1'b0;
    e_bad  = 1'b0;
    e_drop = 1'b0;
  endtask

  task automatic monitor(input int which);
    logic       v, r, l, rs;
    logic [7:0] d;
    logic [8:0] prev = '0;
    logic [8:0] exp;
    logic       stall = 1'b0;
    forever begin
      @(negedge clk);
      if (which == 0) begin v = valid_m; r = ready_m; l = last_m; d = data_m; rs = rst_m; end
      else            begin v = valid_s; r = ready_s; l = last_s; d = data_s; rs = rst_s; end
      if (!rs) begin
        stall = 1'b0;
      end else begin
        if (stall) check((which == 0) ? "m_hold" : "s_hold", {v, l, d}, {1'b1, prev});
        if (v && r) begin
          if (((which == 0) ? q_m.size() : q_s.size()) == 0) begin
            total++;
            nbad++;
            $display("FAIL %s: got byte %0h last %0b, want no byte",
                     (which == 0) ? "m_extra" : "s_extra", d, l);
          end else begin
            exp = (which == 0) ? q_m.pop_front() : q_s.pop_front();
            check((which == 0) ? "m_byte" : "s_byte", {l, d}, exp);
          end
        end
        stall = v && !r;
        prev  = {l, d};
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       ready_m = 1'b0;
        1:       ready_m = 1'b1;
        default: ready_m = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic wait_drain(input int which, input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (which == 0) done = (q_m.size() == 0) && !valid_m;
      else            done = (q_s.size() == 0) && !valid_s;
    end
    if (!done) begin
      total++;
      nbad++;
      $display("FAIL drain_timeout: got %0d bytes outstanding, want 0",
               (which == 0) ? q_m.size() : q_s.size());
    end
  endtask

  initial begin
    rst_m = 1'b0; rst_s = 1'b0; rxd = '0; dvld = 1'b0;
    e_good = 1'b0; e_bad = 1'b0; e_drop = 1'b0; ready_m = 1'b0; ready_s = 1'b0;
    fork
      monitor(0);
      monitor(1);
      ready_driver();
    join_none
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, valid_m}, 0);
    check("rst_last", {31'd0, last_m}, 0);
    check("rst_data", {24'd0, data_m}, 0);
    check("rst_level", {20'd0, level_m}, 0);
    check("rst_ok", {16'd0, ok_m}, 0);
    check("rst_bad", {16'd0, bad_m}, 0);
    check("rst_ovf", {16'd0, ovf_m}, 0);
    rst_m = 1'b1;
    @(posedge clk); #1;

    // 64-byte good frame, with first-byte latency and level checks
    ready_mode = 1;
    send_frame(64, 0, 0, 1);
    @(negedge clk);
    check("level_after_good", {20'd0, level_m}, 64);
    @(negedge clk);
    check("lat_n1_valid", {31'd0, valid_m}, 0);
    @(negedge clk);
    check("lat_n2_valid", {31'd0, valid_m}, 1);
    check("lat_n2_data", {24'd0, data_m}, 0);
    wait_drain(0, 200);
    check("t1_ok", {16'd0, ok_m}, 1);
    check("t1_level", {20'd0, level_m}, 0);

    // bad frame sandwiched between two good frames
    send_frame(10, 'h10, 0, 1);
    send_frame(10, 'h80, 1, 0);
    send_frame(10, 'h20, 0, 1);
    wait_drain(0, 200);
    check("t2_ok", {16'd0, ok_m}, 3);
    check("t2_bad", {16'd0, bad_m}, 1);

    // address-filter drop with GOOD, then GOOD with nothing held
    send_frame(6, 'h40, 2, 0);
    repeat (4) @(negedge clk);
    check("t3_bad", {16'd0, bad_m}, 2);
    check("t3_ok", {16'd0, ok_m}, 3);
    check("t3_level", {20'd0, level_m}, 0);
    check("t3_valid", {31'd0, valid_m}, 0);
    @(posedge clk); #1;
    e_good = 1'b1;
    @(posedge clk); #1;
    e_good = 1'b0;
    @(negedge clk);
    check("idle_status_bad", {16'd0, bad_m}, 3);
    send_frame(4, 'h50, 0, 1);
    wait_drain(0, 100);
    check("t3_ok2", {16'd0, ok_m}, 4);

    // three back-to-back frames under random backpressure
    ready_mode = 2;
    send_frame(7, 'h60, 0, 1);
    send_frame(13, 'h70, 0, 1);
    send_frame(5, 'hA0, 0, 1);
    wait_drain(0, 600);
    ready_mode = 1;
    check("t5_ok", {16'd0, ok_m}, 7);
    check("t5_level", {20'd0, level_m}, 0);

    // reset in the middle of a frame with a committed frame still stalled
    ready_mode = 0;
    send_frame(5, 'h11, 0, 1);
    for (int i = 0; i < 3; i++) begin
      rxd = 8'(8'h30 + i); dvld = 1'b1;
      @(posedge clk); #1;
    end
    check("pre_reset_valid", {31'd0, valid_m}, 1);
    rst_m = 1'b0;
    dvld  = 1'b0;
    q_m.delete();
    @(negedge clk);
    check("mid_rst_valid", {31'd0, valid_m}, 0);
    check("mid_rst_data", {24'd0, data_m}, 0);
    check("mid_rst_last", {31'd0, last_m}, 0);
    check("mid_rst_level", {20'd0, level_m}, 0);
    check("mid_rst_ok", {16'd0, ok_m}, 0);
    @(posedge clk); #1;
    rst_m = 1'b1;
    ready_mode = 1;
    @(posedge clk); #1;
    send_frame(6, 'hC0, 0, 1);
    wait_drain(0, 100);
    check("t6_ok", {16'd0, ok_m}, 1);
    check("t6_level", {20'd0, level_m}, 0);

    // overflow on the 16-entry instance, main instance parked in reset
    rst_m = 1'b0;
    rst_s = 1'b1;
    @(posedge clk); #1;
    send_frame(20, 0, 0, 0);
    repeat (4) @(negedge clk);
    check("ovf_count", {16'd0, ovf_s}, 1);
    check("ovf_ok", {16'd0, ok_s}, 0);
    check("ovf_bad", {16'd0, bad_s}, 0);
    check("ovf_level", {27'd0, level_s}, 0);
    check("ovf_valid", {31'd0, valid_s}, 0);
    @(posedge clk); #1;
    send_frame(8, 'hD0, 0, 2);
    repeat (3) @(negedge clk);
    check("s_level8", {27'd0, level_s}, 8);
    check("s_valid", {31'd0, valid_s}, 1);
    @(posedge clk); #1;
    ready_s = 1'b1;
    wait_drain(1, 100);
    check("s_ok", {16'd0, ok_s}, 1);
    check("s_level0", {27'd0, level_s}, 0);
    check("s_ovf", {16'd0, ovf_s}, 1);

    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end

endmodule
